// File: rtl/oscill_nios_led_pwm_pkg.sv
// Shared register map, CTRL bit positions and default widths for the LED PWM stage.
// Pure declarations: no latency and no backpressure.
package oscill_led_pkg;

    localparam int N_LED_DEF   = 10;
    localparam int PWM_W_DEF   = 8;
    localparam int PRE_W_DEF   = 16;
    localparam int BLINK_W_DEF = 8;

    typedef enum logic [1:0] {
        REG_CTRL       = 2'd0,
        REG_DUTY       = 2'd1,
        REG_PRESCALE   = 2'd2,
        REG_BLINK_HALF = 2'd3
    } reg_addr_e;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_BLINK_BIT = 1;

endpackage

// File: rtl/oscill_nios_led_pwm_if.sv
// Avalon-MM slave bundle for the LED PWM registers; readdata is combinational.
// Latency: 0 cycles on reads, 1 cycle on writes; no backpressure (no waitrequest).
interface oscill_nios_led_pwm_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/oscill_led_pwm_timebase.sv
// Prescaler plus free-running PWM counter; tick/wrap are combinational from the counters.
// Latency: pwm_cnt steps 1 cycle after tick; no backpressure, held at 0 while disabled.
module oscill_led_pwm_timebase #(
    parameter int PWM_W = 8,
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             pre_clr,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick,
    output logic             wrap,
    output logic [PWM_W-1:0] pwm_cnt
);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;

    always_comb begin
        tick      = enable && (pre_cnt_q == prescale);
        wrap      = tick && (&pwm_cnt_q);
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
        pwm_cnt_d = pwm_cnt_q;
        // A prescale write restarts the divider so the new rate starts cleanly.
        if (!enable || pre_clr || tick) begin
            pre_cnt_d = '0;
        end
        if (!enable) begin
            pwm_cnt_d = '0;
        end else if (tick) begin
            pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign pwm_cnt = pwm_cnt_q;

endmodule

// File: rtl/oscill_nios_led_pwm.sv
// LED drive stage: PWM dimming + blink over the PIO pattern; LED_PWM_GAMMA_EN squares the duty.
// Latency: led_drive 1 cycle after led_pattern; no backpressure, Avalon writes always accepted.
module oscill_nios_led_pwm
    import oscill_led_pkg::*;
#(
    parameter int N_LED   = N_LED_DEF,
    parameter int PWM_W   = PWM_W_DEF,
    parameter int PRE_W   = PRE_W_DEF,
    parameter int BLINK_W = BLINK_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_LED-1:0]      led_pattern,
    oscill_nios_led_pwm_if.slave  bus,
    output logic [N_LED-1:0]      led_drive,
    output logic                  pwm_sync
);

    logic [1:0]         ctrl_q, ctrl_d;
    logic [PWM_W-1:0]   duty_shadow_q, duty_shadow_d;
    logic [PWM_W-1:0]   duty_active_q, duty_active_d;
    logic [PRE_W-1:0]   prescale_q, prescale_d;
    logic [BLINK_W-1:0] blink_half_q, blink_half_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [N_LED-1:0]   led_drive_q, led_drive_d;
    logic               pwm_sync_q, pwm_sync_d;

    logic               wr_en, pre_clr, enable, blink_en, load_duty;
    logic               tick, wrap, pwm_on, blink_hold;
    logic [PWM_W-1:0]   pwm_cnt, threshold;
    logic               unused_ok;

    assign enable    = ctrl_q[CTRL_EN_BIT];
    assign blink_en  = ctrl_q[CTRL_BLINK_BIT];
    assign unused_ok = ^{bus.writedata[31:PRE_W], tick};

    oscill_led_pwm_timebase #(
        .PWM_W (PWM_W),
        .PRE_W (PRE_W)
    ) u_timebase (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .pre_clr  (pre_clr),
        .prescale (prescale_q),
        .tick     (tick),
        .wrap     (wrap),
        .pwm_cnt  (pwm_cnt)
    );

    always_comb begin
        wr_en         = bus.chipselect && !bus.write_n;
        pre_clr       = wr_en && (reg_addr_e'(bus.address) == REG_PRESCALE);
        ctrl_d        = ctrl_q;
        duty_shadow_d = duty_shadow_q;
        prescale_d    = prescale_q;
        blink_half_d  = blink_half_q;
        if (wr_en) begin
            case (reg_addr_e'(bus.address))
                REG_CTRL:       ctrl_d        = bus.writedata[1:0];
                REG_DUTY:       duty_shadow_d = bus.writedata[PWM_W-1:0];
                REG_PRESCALE:   prescale_d    = bus.writedata[PRE_W-1:0];
                REG_BLINK_HALF: blink_half_d  = bus.writedata[BLINK_W-1:0];
                default:        ;
            endcase
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (reg_addr_e'(bus.address))
            REG_CTRL:       bus.readdata = 32'(ctrl_q);
            REG_DUTY:       bus.readdata = 32'(duty_shadow_q);
            REG_PRESCALE:   bus.readdata = 32'(prescale_q);
            REG_BLINK_HALF: bus.readdata = 32'(blink_half_q);
            default:        bus.readdata = '0;
        endcase
    end

    // Duty only moves at a period boundary, so a mid-period write never cuts a pulse short.
    assign load_duty = !enable || wrap;

    always_comb begin
        duty_active_d = duty_active_q;
        if (load_duty) begin
            duty_active_d = duty_shadow_q;
        end
    end

`ifdef LED_PWM_GAMMA_EN
    logic [PWM_W-1:0]   eff_q, eff_d;
    logic [2*PWM_W-1:0] duty_sq;

    always_comb begin
        duty_sq = {{PWM_W{1'b0}}, duty_shadow_q} * {{PWM_W{1'b0}}, duty_shadow_q};
        eff_d   = eff_q;
        if (load_duty) begin
            eff_d = PWM_W'(duty_sq >> PWM_W);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eff_q <= '0;
        end else begin
            eff_q <= eff_d;
        end
    end

    assign threshold = eff_q;
`else
    assign threshold = duty_active_q;
`endif

    // Full-scale duty is forced on; a plain compare would leave a one-tick gap.
    assign pwm_on = (&duty_active_q) || (pwm_cnt < threshold);

    always_comb begin
        blink_hold    = !enable || !blink_en || (blink_half_q == '0);
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (blink_hold) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (wrap) begin
            if (blink_cnt_q == blink_half_q - BLINK_W'(1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = !blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    always_comb begin
        led_drive_d = '0;
        if (enable) begin
            led_drive_d = led_pattern & {N_LED{pwm_on & blink_phase_q}};
        end
        pwm_sync_d = wrap;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q        <= '0;
            duty_shadow_q <= '0;
            duty_active_q <= '0;
            prescale_q    <= '0;
            blink_half_q  <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            led_drive_q   <= '0;
            pwm_sync_q    <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            duty_shadow_q <= duty_shadow_d;
            duty_active_q <= duty_active_d;
            prescale_q    <= prescale_d;
            blink_half_q  <= blink_half_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            led_drive_q   <= led_drive_d;
            pwm_sync_q    <= pwm_sync_d;
        end
    end

    assign led_drive = led_drive_q;
    assign pwm_sync  = pwm_sync_q;

endmodule

// File: tb/tb_oscill_nios_led_pwm.sv
// Scoreboard bench for oscill_nios_led_pwm: stimulus queues expectations, a negedge monitor checks them.
module tb_oscill_nios_led_pwm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] led_pattern;
    logic [9:0] led_drive;
    logic       pwm_sync;

    oscill_nios_led_pwm_if bus ();

    oscill_nios_led_pwm dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .led_pattern (led_pattern),
        .bus         (bus.slave),
        .led_drive   (led_drive),
        .pwm_sync    (pwm_sync)
    );

    always #5 clk = ~clk;

    typedef enum {K_CLR, K_LED, K_SYNC, K_RD, K_ON, K_RISE, K_SCNT, K_GAP, K_OR} kind_e;
    typedef struct {
        kind_e kind;
        string name;
        int    exp;
    } item_t;

    item_t      sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         on_cnt = 0, rise_cnt = 0, sync_cnt = 0, since_sync = 0, gap = 0;
    logic [9:0] or_val = '0;
    logic [9:0] prev_led = '0;

    // Expected number of lit cycles in one 256-cycle period for a given duty.
    function automatic int exp_on(input int d);
        if (d == 255) return 256;
`ifdef LED_PWM_GAMMA_EN
        return (d * d) >> 8;
`else
        return d;
`endif
    endfunction

    task automatic push(input kind_e k, input string nm, input int e);
        item_t it;
        it.kind = k;
        it.name = nm;
        it.exp  = e;
        sb.push_back(it);
    endtask

    always @(negedge clk) begin : monitor
        item_t it;
        int    act;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            if (it.kind == K_CLR) begin
                on_cnt   = 0;
                rise_cnt = 0;
                sync_cnt = 0;
                or_val   = '0;
            end else begin
                case (it.kind)
                    K_LED:   act = int'(led_drive);
                    K_SYNC:  act = int'(pwm_sync);
                    K_RD:    act = int'(bus.readdata);
                    K_ON:    act = on_cnt;
                    K_RISE:  act = rise_cnt;
                    K_SCNT:  act = sync_cnt;
                    K_GAP:   act = gap;
                    default: act = int'(or_val);
                endcase
                n_checks++;
                if (act != it.exp) begin
                    n_fail++;
                    $display("FAIL %s: actual 0x%0h required 0x%0h", it.name, act, it.exp);
                end
            end
        end
        if (led_drive != '0) begin
            on_cnt++;
            if (prev_led == '0) rise_cnt++;
        end
        or_val = or_val | led_drive;
        since_sync++;
        if (pwm_sync) begin
            sync_cnt++;
            gap        = since_sync;
            since_sync = 0;
        end
        prev_led = led_drive;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd_chk(input logic [1:0] a, input int e, input string nm);
        bus.address = a;
        push(K_RD, nm, e);
        cyc(1);
    endtask

    // Returns one cycle after the edge that raised pwm_sync (pwm_cnt is then 1).
    task automatic wait_sync();
        bit found = 1'b0;
        for (int i = 0; i < 1100 && !found; i++) begin
            @(negedge clk);
            if (pwm_sync) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_sync: actual no pwm_sync required one within 1100 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n        = 1'b0;
        led_pattern    = 10'h3FF;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        cyc(3);
        push(K_LED, "rst_led", 0);
        push(K_SYNC, "rst_sync", 0);
        cyc(1);
        reset_n = 1'b1;
        cyc(5);
        push(K_LED, "idle_led", 0);
        push(K_SYNC, "idle_sync", 0);
        for (int a = 0; a < 4; a++) rd_chk(2'(a), 0, "idle_rd");

        // Basic dimming at 1/4 duty, no prescale.
        led_pattern = 10'h155;
        wr(2'd2, 32'd0);
        wr(2'd1, 32'h40);
        wr(2'd0, 32'd1);
        rd_chk(2'd0, 1, "rd_ctrl");
        rd_chk(2'd1, 'h40, "rd_duty");
        wait_sync();
        push(K_CLR, "", 0);
        cyc(512);
        push(K_ON, "t1_on", 2 * exp_on('h40));
        push(K_RISE, "t1_rise", 2);
        push(K_SCNT, "t1_sync_cnt", 2);
        push(K_GAP, "t1_sync_gap", 256);
        push(K_OR, "t1_pattern", 'h155);

        // Full-scale and zero duty.
        led_pattern = 10'h2AA;
        wr(2'd1, 32'hFF);
        wait_sync();
        wait_sync();
        cyc(1);
        push(K_CLR, "", 0);
        cyc(256);
        push(K_ON, "t2_full_on", 256);
        push(K_OR, "t2_full_pattern", 'h2AA);
        push(K_LED, "t2_full_led", 'h2AA);
        wr(2'd1, 32'd0);
        wait_sync();
        wait_sync();
        cyc(1);
        push(K_CLR, "", 0);
        cyc(256);
        push(K_ON, "t2_zero_on", 0);
        push(K_LED, "t2_zero_led", 0);

        // Duty changes mid-period and on the wrap cycle.
        led_pattern = 10'h155;
        wr(2'd1, 32'h20);
        wait_sync();
        wait_sync();
        push(K_CLR, "", 0);
        cyc(100);
        wr(2'd1, 32'h80);
        cyc(155);
        push(K_ON, "t3_keep_old", exp_on('h20));
        push(K_RISE, "t3_rise_a", 1);
        push(K_CLR, "", 0);
        cyc(100);
        wr(2'd1, 32'h40);
        cyc(153);
        wr(2'd1, 32'h20);
        cyc(1);
        push(K_ON, "t3_new_at_boundary", exp_on('h80));
        push(K_RISE, "t3_rise_b", 1);
        push(K_SCNT, "t3_sync_b", 1);
        push(K_CLR, "", 0);
        cyc(256);
        push(K_ON, "t3_wrap_write_old_shadow", exp_on('h40));
        push(K_RISE, "t3_rise_c", 1);
        push(K_CLR, "", 0);
        cyc(256);
        push(K_ON, "t3_wrap_write_applied", exp_on('h20));
        rd_chk(2'd1, 'h20, "t3_rd_duty");

        // Blink at 2 periods per half, prescale 4.
        wr(2'd2, 32'd3);
        wr(2'd3, 32'd2);
        wr(2'd1, 32'hFF);
        wr(2'd0, 32'd3);
        wait_sync();
        wait_sync();
        wait_sync();
        push(K_CLR, "", 0);
        cyc(4096);
        push(K_ON, "t4_blink_on", 2048);
        push(K_RISE, "t4_blink_rise", 1);
        push(K_SCNT, "t4_blink_sync_cnt", 4);
        push(K_GAP, "t4_prescaled_gap", 1024);
        wr(2'd3, 32'd0);
        cyc(2);
        push(K_CLR, "", 0);
        cyc(2048);
        push(K_ON, "t4_blink_half0_steady", 2048);
        rd_chk(2'd0, 3, "t4_rd_ctrl");
        rd_chk(2'd2, 3, "t4_rd_prescale");
        rd_chk(2'd3, 0, "t4_rd_blink_half");

        // Disable, then re-enable restarts the period at pwm_cnt = 0.
        wr(2'd0, 32'd0);
        cyc(1);
        push(K_LED, "t5_disabled_led", 0);
        push(K_CLR, "", 0);
        cyc(300);
        push(K_ON, "t5_disabled_on", 0);
        push(K_SCNT, "t5_disabled_sync", 0);
        wr(2'd2, 32'd0);
        wr(2'd1, 32'h40);
        wr(2'd0, 32'd1);
        push(K_CLR, "", 0);
        cyc(256);
        push(K_ON, "t5_reenable_on", exp_on('h40));
        push(K_RISE, "t5_reenable_rise", 1);
        push(K_SYNC, "t5_first_sync", 1);

        // Asynchronous reset in the on-phase.
        wr(2'd1, 32'h80);
        wait_sync();
        wait_sync();
        cyc(1);
        push(K_CLR, "", 0);
        cyc(256);
        push(K_ON, "t6_duty80_on", exp_on('h80));
        cyc(10);
        push(K_LED, "t6_before_reset", 'h155);
        cyc(1);
        #1;
        reset_n = 1'b0;
        push(K_LED, "t6_async_reset_led", 0);
        push(K_SYNC, "t6_async_reset_sync", 0);
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
        for (int a = 0; a < 4; a++) rd_chk(2'(a), 0, "t6_rd_after_reset");
        push(K_LED, "t6_led_after_reset", 0);
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
